// File: rtl/phys_reg_file_rrat.sv
// Physical register file with ready scoreboard and retirement RAT (committed arch->phys map).
// Optional same-edge write forwarding on all read paths when PRF_BYPASS_EN is defined.
module phys_reg_file_rrat #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_PREG = 64,
  parameter int unsigned NUM_AREG = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_RD*$clog2(NUM_PREG)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]          rd_data,
  output logic [NUM_RD-1:0]                 rd_ready,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR*$clog2(NUM_PREG)-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]          wr_data,
  input  logic                              alloc_en,
  input  logic [$clog2(NUM_PREG)-1:0]       alloc_preg,
  input  logic                              commit_en,
  input  logic [$clog2(NUM_AREG)-1:0]       commit_areg,
  input  logic [$clog2(NUM_PREG)-1:0]       commit_preg,
  input  logic [$clog2(NUM_AREG)-1:0]       arch_rd_areg,
  output logic [DATA_W-1:0]                 arch_rd_data
);

  localparam int unsigned PREG_W = $clog2(NUM_PREG);
  localparam int unsigned AREG_W = $clog2(NUM_AREG);

  logic [DATA_W-1:0] regs  [NUM_PREG];
  logic              ready [NUM_PREG];
  logic [PREG_W-1:0] rrat  [NUM_AREG];

  logic [PREG_W-1:0] ra      [NUM_RD];
  logic [PREG_W-1:0] wa      [NUM_WR];
  logic [DATA_W-1:0] wd      [NUM_WR];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic [PREG_W-1:0] arch_preg;
  logic [DATA_W-1:0] arch_next;

  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra[i] = rd_addr[i*PREG_W +: PREG_W];
    end
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wa[k] = wr_addr[k*PREG_W +: PREG_W];
      wd[k] = wr_data[k*DATA_W +: DATA_W];
    end
  end

  // Operand read path: pre-edge state, optionally overridden by the highest matching write port.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_next[i]  = (ra[i] == '0) ? '0 : regs[ra[i]];
      rd_ready[i] = (ra[i] == '0) ? 1'b1 : ready[ra[i]];
`ifdef PRF_BYPASS_EN
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wa[k] == ra[i]) && (ra[i] != '0)) begin
          rd_next[i] = wd[k];
          if (!(alloc_en && (alloc_preg == ra[i]))) begin
            rd_ready[i] = 1'b1;
          end
        end
      end
`endif
    end
  end

  always_comb begin
    arch_preg = rrat[arch_rd_areg];
    arch_next = (arch_preg == '0) ? '0 : regs[arch_preg];
`ifdef PRF_BYPASS_EN
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wa[k] == arch_preg) && (arch_preg != '0)) begin
        arch_next = wd[k];
      end
    end
`endif
  end

  // Later ports overwrite earlier ones; alloc is applied last so it beats any write's ready-set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned p = 0; p < NUM_PREG; p++) begin
        regs[p]  <= '0;
        ready[p] <= 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wa[k] != '0)) begin
          regs[wa[k]]  <= wd[k];
          ready[wa[k]] <= 1'b1;
        end
      end
      if (alloc_en && (alloc_preg != '0)) begin
        ready[alloc_preg] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned a = 0; a < NUM_AREG; a++) begin
        rrat[a] <= PREG_W'(a);
      end
    end else if (commit_en && (commit_preg != '0)) begin
      rrat[commit_areg] <= commit_preg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data      <= '0;
      arch_rd_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
      end
      arch_rd_data <= arch_next;
    end
  end

  logic unused_areg_w;
  assign unused_areg_w = (AREG_W == 0);

endmodule

// File: tb/tb_phys_reg_file_rrat.sv
// Directed-vector bench for phys_reg_file_rrat with a due-cycle scoreboard and a negedge monitor.
module tb_phys_reg_file_rrat;

`ifdef PRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [11:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic [1:0]  wr_en = '0;
  logic [11:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        alloc_en = 1'b0;
  logic [5:0]  alloc_preg = '0;
  logic        commit_en = 1'b0;
  logic [4:0]  commit_areg = '0;
  logic [5:0]  commit_preg = '0;
  logic [4:0]  arch_rd_areg = '0;
  logic [31:0] arch_rd_data;

  phys_reg_file_rrat #(.DATA_W(32), .NUM_PREG(64), .NUM_AREG(32), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_preg(alloc_preg),
    .commit_en(commit_en), .commit_areg(commit_areg), .commit_preg(commit_preg),
    .arch_rd_areg(arch_rd_areg), .arch_rd_data(arch_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 rd_data[0], 1 rd_data[1], 2 arch_rd_data, 3 rd_ready[0], 4 rd_ready[1]
  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0:       return rd_data[31:0];
      1:       return rd_data[63:32];
      2:       return arch_rd_data;
      3:       return {31'd0, rd_ready[0]};
      default: return {31'd0, rd_ready[1]};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].due <= cyc) begin
        checks++;
        if (actual(sb[j].kind) === sb[j].exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                      sb[j].name, actual(sb[j].kind), sb[j].exp, cyc);
        sb.delete(j);
      end
    end
  end

  task automatic push(input int lat, input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.due = cyc + lat; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; alloc_en = 1'b0; commit_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*6 +: 6] = 6'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*6 +: 6] = 6'(a);
    wr_data[p*32 +: 32] = d;
  endtask

  initial begin
    #3 rstn = 1'b0;
    step();
    push(0, 0, 32'h0, "reset_rd0");
    push(0, 1, 32'h0, "reset_rd1");
    push(0, 2, 32'h0, "reset_arch");
    step();
    rstn = 1'b1;
    step();

    // 1: arch reads all zero, every preg ready
    for (int a = 0; a < 32; a++) begin
      arch_rd_areg = 5'(a); set_rd(0, a); set_rd(1, a + 32);
      push(1, 2, 32'h0, "reset_arch_sweep");
      push(0, 3, 32'h1, "reset_ready_lo");
      push(0, 4, 32'h1, "reset_ready_hi");
      step();
    end
    set_wr(0, 7, 32'h77); set_wr(1, 31, 32'h3131);
    step();
    idle(); arch_rd_areg = 5'd7; push(1, 2, 32'h77, "identity_a7");
    step();
    arch_rd_areg = 5'd31; push(1, 2, 32'h3131, "identity_a31");
    step();

    // 2: basic write then read
    set_wr(0, 5, 32'hDEADBEEF);
    step();
    idle(); set_rd(0, 5); push(1, 0, 32'hDEADBEEF, "wr_rd_p5");
    step();

    // 3: same-address write ports, higher port wins
    set_wr(0, 9, 32'h11); set_wr(1, 9, 32'h22);
    step();
    idle(); set_rd(1, 9); push(1, 1, 32'h22, "port_priority_p9");
    step();

    // 4: preg 0 is hardwired
    set_wr(0, 0, 32'hFFFF);
    step();
    idle(); set_rd(0, 0); alloc_en = 1'b1; alloc_preg = 6'd0;
    push(1, 0, 32'h0, "p0_read_zero");
    push(0, 3, 32'h1, "p0_ready_alloc_cycle");
    step();
    idle(); push(0, 3, 32'h1, "p0_ready_after_alloc");
    step();

    // 5: alloc / write interaction on ready
    alloc_en = 1'b1; alloc_preg = 6'd12;
    step();
    idle(); set_rd(0, 12); push(0, 3, 32'h0, "alloc_clears_ready");
    step();
    set_wr(0, 12, 32'h6); push(0, 3, BYP ? 32'h1 : 32'h0, "ready_during_write");
    step();
    idle(); push(0, 3, 32'h1, "write_sets_ready"); push(1, 0, 32'h6, "p12_data_first");
    step();
    set_wr(0, 12, 32'h7); alloc_en = 1'b1; alloc_preg = 6'd12;
    push(0, 3, 32'h1, "ready_alloc_write_cycle");
    step();
    idle(); push(0, 3, 32'h0, "alloc_beats_write"); push(1, 0, 32'h7, "alloc_write_data");
    step();

    // 6: commit then arch read; commit of preg 0 ignored; same-edge commit visible next cycle
    set_wr(0, 40, 32'hABCD); commit_en = 1'b1; commit_areg = 5'd10; commit_preg = 6'd40;
    step();
    idle(); arch_rd_areg = 5'd10; push(1, 2, 32'hABCD, "commit_a10_p40");
    step();
    commit_en = 1'b1; commit_areg = 5'd10; commit_preg = 6'd0;
    step();
    idle(); push(1, 2, 32'hABCD, "commit_p0_ignored");
    step();
    commit_en = 1'b1; commit_areg = 5'd11; commit_preg = 6'd40; arch_rd_areg = 5'd11;
    push(1, 2, 32'h0, "commit_same_edge_old");
    step();
    idle(); push(1, 2, 32'hABCD, "commit_visible_next");
    step();

    // 7: same-edge write and read of p3
    set_wr(0, 3, 32'h33);
    step();
    idle(); set_wr(0, 3, 32'h55); set_rd(0, 3); arch_rd_areg = 5'd3;
    push(1, 0, BYP ? 32'h55 : 32'h33, "same_edge_rd_p3");
    push(1, 2, BYP ? 32'h55 : 32'h33, "same_edge_arch_a3");
    step();
    idle(); push(1, 0, 32'h55, "p3_after_write");
    step();
    set_wr(0, 20, 32'hA); set_wr(1, 20, 32'hB); set_rd(1, 20);
    push(1, 1, BYP ? 32'hB : 32'h0, "same_edge_priority_p20");
    step();
    idle();

    // 8: async reset in the middle of a write/commit burst
    for (int i = 0; i < 3; i++) begin
      set_wr(0, 5, 32'h100 + 32'(i)); commit_en = 1'b1; commit_areg = 5'd10; commit_preg = 6'd5;
      set_rd(0, 5); set_rd(1, 12); arch_rd_areg = 5'd10;
      step();
    end
    #2 rstn = 1'b0;
    push(0, 0, 32'h0, "midreset_rd0");
    push(0, 1, 32'h0, "midreset_rd1");
    push(0, 2, 32'h0, "midreset_arch");
    push(0, 4, 32'h1, "midreset_ready_p12");
    step();
    idle(); rstn = 1'b1;
    step();
    set_wr(0, 10, 32'h1010); set_rd(0, 5); push(1, 0, 32'h0, "p5_cleared_by_reset");
    step();
    idle(); arch_rd_areg = 5'd10; push(1, 2, 32'h1010, "rrat_identity_after_reset");
    step();

    for (int t = 0; t < 10 && sb.size() != 0; t++) step();
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
